// File: rtl/rom_access_ctrl.sv
// rtl/rom_access_ctrl.sv - ROM access arbiter between CPU instruction fetch and buffered JTAG writes
// Halts the CPU, drains the JTAG write buffer into ROM in order, then releases after an idle window.
module rom_access_ctrl #(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_RELEASE = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jtag_wen,
  input  logic [AW-1:0] jtag_w_addr,
  input  logic [DW-1:0] jtag_w_data,
  input  logic          ext_halt,
  input  logic [AW-1:0] cpu_fetch_addr,
  input  logic          cpu_halt_ack,
  output logic          cpu_halt_req,
  output logic          cpu_inst_valid,
  output logic          rom_ren,
  output logic [AW-1:0] rom_r_addr,
  output logic          rom_wen,
  output logic [AW-1:0] rom_w_addr,
  output logic [DW-1:0] rom_w_data,
  output logic          fifo_full,
  output logic [7:0]    drop_cnt,
  output logic          busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW = $clog2(IDLE_RELEASE + 1);
  localparam logic [PW:0]   LP_DEPTH    = (PW + 1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LP_IDLE_MAX = IW'(IDLE_RELEASE - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT_REQ,
    S_WRITE,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_mem_addr [FIFO_DEPTH];
  logic [DW-1:0] r_mem_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [IW-1:0] r_idle;
  logic [7:0]    r_drop;
  logic          r_inst_valid;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);
  assign w_pop   = (r_state == S_WRITE) && !w_empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign w_push  = jtag_wen && (!w_full || w_pop);
  assign w_drop  = jtag_wen && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_addr[r_wr_ptr] <= jtag_w_addr;
      r_mem_data[r_wr_ptr] <= jtag_w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_idle       <= '0;
      r_drop       <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_inst_valid <= (r_state == S_RUN);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW + 1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW + 1)'(1);
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      // Idle counter only runs in WAIT and saturates there while ext_halt holds us.
      if ((r_state == S_WAIT) && w_empty) begin
        if (r_idle != LP_IDLE_MAX) r_idle <= r_idle + IW'(1);
      end else begin
        r_idle <= '0;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    cpu_halt_req = 1'b0;
    rom_ren      = 1'b0;
    case (r_state)
      S_RUN: begin
        rom_ren = 1'b1;
        if (!w_empty || ext_halt) w_next = S_HALT_REQ;
      end
      S_HALT_REQ: begin
        cpu_halt_req = 1'b1;
        if (cpu_halt_ack) w_next = S_WRITE;
      end
      S_WRITE: begin
        cpu_halt_req = 1'b1;
        if (w_empty) w_next = S_WAIT;
      end
      S_WAIT: begin
        cpu_halt_req = 1'b1;
        if (!w_empty) w_next = S_WRITE;
        else if ((r_idle == LP_IDLE_MAX) && !ext_halt) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!w_empty || ext_halt) w_next = S_HALT_REQ;
        else if (!cpu_halt_ack)   w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  assign rom_r_addr     = cpu_fetch_addr;
  assign rom_wen        = w_pop;
  assign rom_w_addr     = r_mem_addr[r_rd_ptr];
  assign rom_w_data     = r_mem_data[r_rd_ptr];
  assign cpu_inst_valid = r_inst_valid;
  assign fifo_full      = w_full;
  assign drop_cnt       = r_drop;
  assign busy           = (r_state != S_RUN);

endmodule

// File: tb/tb_rom_access_ctrl.sv
// tb/tb_rom_access_ctrl.sv - self-checking bench for rom_access_ctrl
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_rom_access_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int IDLE  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          jtag_wen;
  logic [AW-1:0] jtag_w_addr;
  logic [DW-1:0] jtag_w_data;
  logic          ext_halt;
  logic [AW-1:0] cpu_fetch_addr;
  logic          cpu_halt_ack;
  logic          cpu_halt_req;
  logic          cpu_inst_valid;
  logic          rom_ren;
  logic [AW-1:0] rom_r_addr;
  logic          rom_wen;
  logic [AW-1:0] rom_w_addr;
  logic [DW-1:0] rom_w_data;
  logic          fifo_full;
  logic [7:0]    drop_cnt;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [AW-1:0] ent_addr [8];
  logic [DW-1:0] ent_data [8];

  rom_access_ctrl #(.DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH), .IDLE_RELEASE(IDLE)) dut (
    .clk(clk), .rst(rst), .jtag_wen(jtag_wen), .jtag_w_addr(jtag_w_addr),
    .jtag_w_data(jtag_w_data), .ext_halt(ext_halt), .cpu_fetch_addr(cpu_fetch_addr),
    .cpu_halt_ack(cpu_halt_ack), .cpu_halt_req(cpu_halt_req), .cpu_inst_valid(cpu_inst_valid),
    .rom_ren(rom_ren), .rom_r_addr(rom_r_addr), .rom_wen(rom_wen), .rom_w_addr(rom_w_addr),
    .rom_w_data(rom_w_data), .fifo_full(fifo_full), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; jtag_wen = 1'b0; jtag_w_addr = '0; jtag_w_data = '0;
    ext_halt = 1'b0; cpu_fetch_addr = 32'h100; cpu_halt_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_entries(input int n);
    for (int i = 0; i < n; i++) begin
      ent_addr[i] = 32'h10 + i;
      ent_data[i] = $urandom;
      jtag_wen = 1'b1; jtag_w_addr = ent_addr[i]; jtag_w_data = ent_data[i];
      tick();
    end
    jtag_wen = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; jtag_wen = 1'b1; jtag_w_addr = 32'h44; jtag_w_data = 32'h1234;
    ext_halt = 1'b0; cpu_fetch_addr = 32'h100; cpu_halt_ack = 1'b0;
    tick(); tick(); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (cpu_halt_req !== 1'b0) $display("FAIL rst_halt_req: got %b expected 0", cpu_halt_req); else n_pass++;
    n_total++; if (rom_wen !== 1'b0) $display("FAIL rst_rom_wen: got %b expected 0", rom_wen); else n_pass++;
    n_total++; if (fifo_full !== 1'b0) $display("FAIL rst_fifo_full: got %b expected 0", fifo_full); else n_pass++;
    n_total++; if (drop_cnt !== 8'd0) $display("FAIL rst_drop_cnt: got %0d expected 0", drop_cnt); else n_pass++;
    n_total++; if (cpu_inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b expected 0", cpu_inst_valid); else n_pass++;
    rst = 1'b0; jtag_wen = 1'b0;
    tick(); tick(); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_jtag_ignored: got busy=%b expected 0", busy); else n_pass++;
  endtask

  task automatic test_fetch();
    do_reset();
    n_total++; if (rom_ren !== 1'b1) $display("FAIL fetch_ren: got %b expected 1", rom_ren); else n_pass++;
    n_total++; if (rom_r_addr !== 32'h100) $display("FAIL fetch_addr: got %h expected 00000100", rom_r_addr); else n_pass++;
    n_total++; if (cpu_inst_valid !== 1'b0) $display("FAIL fetch_valid_early: got %b expected 0", cpu_inst_valid); else n_pass++;
    tick(); #1;
    n_total++; if (cpu_inst_valid !== 1'b1) $display("FAIL fetch_valid: got %b expected 1", cpu_inst_valid); else n_pass++;
    cpu_fetch_addr = 32'h2A4; #1;
    n_total++; if (rom_r_addr !== 32'h2A4) $display("FAIL fetch_addr2: got %h expected 000002a4", rom_r_addr); else n_pass++;
  endtask

  task automatic test_single_write();
    int n;
    int wen_cnt;
    do_reset();
    jtag_wen = 1'b1; jtag_w_addr = 32'h8; jtag_w_data = 32'hDEADBEEF;
    tick(); jtag_wen = 1'b0;
    tick(); #1;
    n_total++; if (cpu_halt_req !== 1'b1) $display("FAIL sw_halt_req: got %b expected 1", cpu_halt_req); else n_pass++;
    n_total++; if (rom_ren !== 1'b0) $display("FAIL sw_ren_off: got %b expected 0", rom_ren); else n_pass++;
    tick(); cpu_halt_ack = 1'b1;
    tick(); #1;
    n_total++; if (rom_wen !== 1'b1 || rom_w_addr !== 32'h8 || rom_w_data !== 32'hDEADBEEF)
      $display("FAIL sw_rom_write: got wen=%b addr=%h data=%h expected 1/00000008/deadbeef", rom_wen, rom_w_addr, rom_w_data);
    else n_pass++;
    n = 0; wen_cnt = 0;
    while (cpu_halt_req && n < 100) begin
      tick(); #1; n++;
      if (rom_wen) wen_cnt++;
    end
    // one trailing WRITE cycle that sees the buffer empty, IDLE cycles in WAIT, then RELEASE
    n_total++; if (n !== IDLE + 2) $display("FAIL sw_halt_to_release_cycles: got %0d expected %0d", n, IDLE + 2); else n_pass++;
    n_total++; if (wen_cnt !== 0) $display("FAIL sw_single_write: got %0d extra writes expected 0", wen_cnt); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL sw_release_busy: got %b expected 1", busy); else n_pass++;
    cpu_halt_ack = 1'b0;
    tick(); #1;
    n_total++; if (busy !== 1'b0 || rom_ren !== 1'b1) $display("FAIL sw_back_to_run: got busy=%b ren=%b expected 0/1", busy, rom_ren); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    push_entries(6);
    n_total++; if (fifo_full !== 1'b1) $display("FAIL ovf_full: got %b expected 1", fifo_full); else n_pass++;
    n_total++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); else n_pass++;
    n_total++; if (rom_wen !== 1'b0 || cpu_halt_req !== 1'b1) $display("FAIL ovf_halted: got wen=%b halt_req=%b expected 0/1", rom_wen, cpu_halt_req); else n_pass++;
    cpu_halt_ack = 1'b1;
    tick(); #1;
    for (int i = 0; i < DEPTH; i++) begin
      n_total++; if (rom_wen !== 1'b1 || rom_w_addr !== ent_addr[i] || rom_w_data !== ent_data[i])
        $display("FAIL ovf_write%0d: got wen=%b addr=%h data=%h expected 1/%h/%h", i, rom_wen, rom_w_addr, rom_w_data, ent_addr[i], ent_data[i]);
      else n_pass++;
      tick(); #1;
    end
    n_total++; if (rom_wen !== 1'b0 || fifo_full !== 1'b0) $display("FAIL ovf_drained: got wen=%b full=%b expected 0/0", rom_wen, fifo_full); else n_pass++;
  endtask

  task automatic test_full_pop_push();
    do_reset();
    push_entries(DEPTH);
    n_total++; if (fifo_full !== 1'b1 || drop_cnt !== 8'd0) $display("FAIL fpp_full: got full=%b drop=%0d expected 1/0", fifo_full, drop_cnt); else n_pass++;
    cpu_halt_ack = 1'b1;
    tick(); #1;
    n_total++; if (rom_wen !== 1'b1 || rom_w_data !== ent_data[0]) $display("FAIL fpp_first: got wen=%b data=%h expected 1/%h", rom_wen, rom_w_data, ent_data[0]); else n_pass++;
    ent_addr[DEPTH] = 32'h77; ent_data[DEPTH] = $urandom;
    jtag_wen = 1'b1; jtag_w_addr = ent_addr[DEPTH]; jtag_w_data = ent_data[DEPTH];
    tick(); jtag_wen = 1'b0; #1;
    n_total++; if (drop_cnt !== 8'd0) $display("FAIL fpp_drop_cnt: got %0d expected 0", drop_cnt); else n_pass++;
    n_total++; if (fifo_full !== 1'b1) $display("FAIL fpp_still_full: got %b expected 1", fifo_full); else n_pass++;
    for (int i = 1; i <= DEPTH; i++) begin
      n_total++; if (rom_wen !== 1'b1 || rom_w_addr !== ent_addr[i] || rom_w_data !== ent_data[i])
        $display("FAIL fpp_write%0d: got wen=%b addr=%h data=%h expected 1/%h/%h", i, rom_wen, rom_w_addr, rom_w_data, ent_addr[i], ent_data[i]);
      else n_pass++;
      tick(); #1;
    end
  endtask

  task automatic test_ext_halt();
    int released;
    do_reset();
    ext_halt = 1'b1;
    tick(); #1;
    n_total++; if (cpu_halt_req !== 1'b1) $display("FAIL eh_halt_req: got %b expected 1", cpu_halt_req); else n_pass++;
    cpu_halt_ack = 1'b1;
    released = 0;
    for (int i = 0; i < 50; i++) begin
      tick(); #1;
      if (!cpu_halt_req || rom_wen) released++;
    end
    n_total++; if (released !== 0) $display("FAIL eh_hold: got %0d released cycles expected 0", released); else n_pass++;
    ext_halt = 1'b0;
    tick(); #1;
    n_total++; if (cpu_halt_req !== 1'b0 || busy !== 1'b1) $display("FAIL eh_release: got halt_req=%b busy=%b expected 0/1", cpu_halt_req, busy); else n_pass++;
    cpu_halt_ack = 1'b0;
    tick(); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL eh_run: got busy=%b expected 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    push_entries(DEPTH);
    cpu_halt_ack = 1'b1;
    tick(); tick(); #1;
    n_total++; if (rom_wen !== 1'b1 || rom_w_data !== ent_data[1]) $display("FAIL rmw_in_write: got wen=%b data=%h expected 1/%h", rom_wen, rom_w_data, ent_data[1]); else n_pass++;
    rst = 1'b1; cpu_halt_ack = 1'b0;
    tick(); rst = 1'b0; #1;
    n_total++; if (busy !== 1'b0 || rom_wen !== 1'b0 || fifo_full !== 1'b0 || cpu_halt_req !== 1'b0)
      $display("FAIL rmw_after_reset: got busy=%b wen=%b full=%b halt_req=%b expected 0/0/0/0", busy, rom_wen, fifo_full, cpu_halt_req);
    else n_pass++;
    tick(); #1;
    n_total++; if (busy !== 1'b0 || rom_wen !== 1'b0) $display("FAIL rmw_fifo_empty: got busy=%b wen=%b expected 0/0", busy, rom_wen); else n_pass++;
  endtask

  task automatic test_random();
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    int  model_drop;
    bit  prev_run;
    int  c;
    do_reset();
    model_drop = 0; prev_run = 1'b0;
    for (c = 0; c < 1200; c++) begin
      if (c < 1000) begin
        jtag_wen = ($urandom_range(0, 99) < 35);
        jtag_w_addr = $urandom; jtag_w_data = $urandom;
        if ($urandom_range(0, 99) < 3) ext_halt = ~ext_halt;
      end else begin
        jtag_wen = 1'b0; ext_halt = 1'b0;
        if (!busy && q_addr.size() == 0) break;
      end
      if (cpu_halt_req && !cpu_halt_ack && $urandom_range(0, 1) == 1) cpu_halt_ack = 1'b1;
      else if (!cpu_halt_req && cpu_halt_ack && $urandom_range(0, 1) == 1) cpu_halt_ack = 1'b0;
      #1;
      n_total++; if (cpu_inst_valid !== prev_run) $display("FAIL rnd_inst_valid c%0d: got %b expected %b", c, cpu_inst_valid, prev_run); else n_pass++;
      n_total++; if (fifo_full !== (q_addr.size() == DEPTH)) $display("FAIL rnd_full c%0d: got %b expected %b", c, fifo_full, q_addr.size() == DEPTH); else n_pass++;
      n_total++; if (drop_cnt !== model_drop[7:0]) $display("FAIL rnd_drop c%0d: got %0d expected %0d", c, drop_cnt, model_drop); else n_pass++;
      if (rom_wen) begin
        n_total++;
        if (q_addr.size() == 0) $display("FAIL rnd_spurious_write c%0d: got wen=1 expected no pending entry", c);
        else if (rom_w_addr !== q_addr[0] || rom_w_data !== q_data[0] || rom_ren !== 1'b0)
          $display("FAIL rnd_write c%0d: got addr=%h data=%h ren=%b expected %h/%h/0", c, rom_w_addr, rom_w_data, rom_ren, q_addr[0], q_data[0]);
        else n_pass++;
      end
      prev_run = !busy;
      if (rom_wen && q_addr.size() != 0) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (jtag_wen) begin
        if (q_addr.size() < DEPTH) begin
          q_addr.push_back(jtag_w_addr);
          q_data.push_back(jtag_w_data);
        end else if (model_drop < 255) begin
          model_drop++;
        end
      end
      tick();
    end
    #1;
    n_total++; if (busy !== 1'b0 || q_addr.size() != 0) $display("FAIL rnd_drain: got busy=%b pending=%0d expected 0/0", busy, q_addr.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_single_write();
    test_overflow();
    test_full_pop_push();
    test_ext_halt();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
